// File: rtl/mand_pkg.sv
// rtl/mand_pkg.sv - shared constants, FSM states and slot tag for the Mandelbrot frame scheduler
package mand_pkg;
    localparam int NTHR = 11;
    localparam int CW   = 7;
    localparam int XW   = 12;
    localparam int YW   = 10;
    localparam int CHW  = 8;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADV, FLUSH} state_t;

    typedef struct packed {
        logic [CHW-1:0] chunk;
        logic [YW-1:0]  row;
        logic           last;
    } slot_tag_t;
endpackage

// File: rtl/mand_pixbuf.sv
// rtl/mand_pixbuf.sv - 2-slot ping-pong counter buffer with 11:1 pixel serialiser
module mand_pixbuf import mand_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 free,
    input  logic                 reserve,
    input  logic                 wr_en,
    input  logic [NTHR*CW-1:0]   wr_counters,
    input  slot_tag_t            wr_tag,
    output logic                 empty,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [CW-1:0]        pix_data,
    output logic [XW-1:0]        pix_x,
    output logic [YW-1:0]        pix_y,
    output logic                 pix_last
);
    logic [NTHR-1:0][CW-1:0] mem [2];
    slot_tag_t               tag [2];
    logic [1:0]              occ;
    logic [1:0]              full;
    logic                    wr_ptr;
    logic                    rd_ptr;
    logic [3:0]              k;
    logic                    fire;
    logic                    drain_last;
    logic [XW-1:0]           base_x;

    // Slots are reserved, written and drained strictly in order, so a
    // request only ever writes the slot most recently reserved (~wr_ptr).
    assign pix_valid  = full[rd_ptr];
    assign fire       = pix_valid && pix_ready;
    assign drain_last = fire && (k == 4'(NTHR - 1));
    assign free       = !occ[wr_ptr] || ((rd_ptr == wr_ptr) && drain_last);
    assign empty      = (occ == 2'b00);

    assign pix_data = mem[rd_ptr][k];
    assign base_x   = (XW'(tag[rd_ptr].chunk) << 3) + (XW'(tag[rd_ptr].chunk) << 1)
                    + XW'(tag[rd_ptr].chunk);
    assign pix_x    = base_x + XW'(k);
    assign pix_y    = tag[rd_ptr].row;
    assign pix_last = pix_valid && tag[rd_ptr].last && (k == 4'(NTHR - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            occ    <= 2'b00;
            full   <= 2'b00;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            k      <= 4'd0;
            for (int s = 0; s < 2; s++) begin
                mem[s] <= '0;
                tag[s] <= '0;
            end
        end else begin
            if (fire) begin
                if (k == 4'(NTHR - 1)) begin
                    k            <= 4'd0;
                    occ[rd_ptr]  <= 1'b0;
                    full[rd_ptr] <= 1'b0;
                    rd_ptr       <= ~rd_ptr;
                end else begin
                    k <= k + 4'd1;
                end
            end
            if (wr_en) begin
                mem[~wr_ptr]  <= wr_counters;
                tag[~wr_ptr]  <= wr_tag;
                full[~wr_ptr] <= 1'b1;
            end
            // Placed after the drain clear so a slot freed and re-reserved
            // in the same cycle ends up occupied.
            if (reserve) begin
                occ[wr_ptr] <= 1'b1;
                wr_ptr      <= ~wr_ptr;
            end
        end
    end
endmodule

// File: rtl/mand_frame_sched.sv
// rtl/mand_frame_sched.sv - frame walker issuing 11-pixel chunk requests and streaming results
module mand_frame_sched import mand_pkg::*; (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [31:0]          cfg_x0,
    input  logic [31:0]          cfg_y0,
    input  logic [31:0]          cfg_xstep,
    input  logic [31:0]          cfg_ystep,
    input  logic [7:0]           cfg_chunks,
    input  logic [YW-1:0]        cfg_rows,
    output logic                 busy,
    output logic                 done,
    output logic                 core_rq,
    output logic [31:0]          core_cx0,
    output logic [31:0]          core_cxstep,
    output logic [31:0]          core_cy,
    input  logic                 core_ack,
    input  logic [NTHR*CW-1:0]   core_counters,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [CW-1:0]        pix_data,
    output logic [XW-1:0]        pix_x,
    output logic [YW-1:0]        pix_y,
    output logic                 pix_last
);
    state_t         state, state_nxt;
    logic [31:0]    x0, xstep, ystep, xstep11, cx, cy;
    logic [CHW-1:0] chunk, last_chunk;
    logic [YW-1:0]  row, last_row;
    logic           is_last_chunk, is_last_row;
    logic           free, empty, reserve, wr_en;
    slot_tag_t      wr_tag;

    assign is_last_chunk = (chunk == last_chunk);
    assign is_last_row   = (row == last_row);
    assign busy          = (state != IDLE);
    assign core_cx0      = cx;
    assign core_cy       = cy;
    assign core_cxstep   = xstep;
    assign wr_en         = (state == WAIT) && core_ack;
    assign wr_tag        = '{chunk: chunk, row: row, last: is_last_chunk && is_last_row};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        core_rq   = 1'b0;
        reserve   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: if (free) begin
                core_rq   = 1'b1;
                reserve   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  if (core_ack) state_nxt = ADV;
            ADV:   state_nxt = (is_last_chunk && is_last_row) ? FLUSH : ISSUE;
            FLUSH: if (empty) begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Position registers only move in ADV, which keeps the core inputs
    // stable from the request through its ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            x0 <= '0; xstep <= '0; ystep <= '0; xstep11 <= '0;
            cx <= '0; cy <= '0;
            chunk <= '0; last_chunk <= '0;
            row <= '0; last_row <= '0;
        end else if (state == IDLE && start) begin
            x0         <= cfg_x0;
            xstep      <= cfg_xstep;
            ystep      <= cfg_ystep;
            xstep11    <= (cfg_xstep << 3) + (cfg_xstep << 1) + cfg_xstep;
            cx         <= cfg_x0;
            cy         <= cfg_y0;
            chunk      <= '0;
            row        <= '0;
            last_chunk <= (cfg_chunks == 8'd0) ? 8'd0 : cfg_chunks - 8'd1;
            last_row   <= (cfg_rows == '0) ? '0 : cfg_rows - YW'(1);
        end else if (state == ADV) begin
            if (!is_last_chunk) begin
                chunk <= chunk + 8'd1;
                cx    <= cx + xstep11;
            end else if (!is_last_row) begin
                chunk <= '0;
                cx    <= x0;
                row   <= row + YW'(1);
                cy    <= cy + ystep;
            end
        end
    end

    mand_pixbuf u_pixbuf (
        .clk         (clk),
        .reset       (reset),
        .free        (free),
        .reserve     (reserve),
        .wr_en       (wr_en),
        .wr_counters (core_counters),
        .wr_tag      (wr_tag),
        .empty       (empty),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_last    (pix_last)
    );
endmodule

// File: doc/mand_frame_sched.md
Name: mand_frame_sched

Overview:
- Frame-level scheduler for the 11-thread Mandelbrot pipeline core (rq/ack, cx0/cxstep/cy in, 77-bit packed counters out).
- Walks a rectangular frame in row-major order, in chunks of 11 pixels, and issues one core request per chunk.
- Captures each chunk's packed iteration counters into a 2-entry ping-pong buffer.
- Serialises the buffered counters as a valid/ready pixel stream with coordinates.
- Sits between the host control registers and the frame-buffer writer.

Parameters:
- NTHR, 11, threads per core request (pixels per chunk).
- CW, 7, iteration-counter width per pixel.
- XW, 12, pixel column index width.
- YW, 10, row index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin frame; sampled only while idle.
- cfg_x0  in  32  fixed-point x of the leftmost pixel.
- cfg_y0  in  32  fixed-point y of row 0.
- cfg_xstep  in  32  x increment per pixel.
- cfg_ystep  in  32  y increment per row.
- cfg_chunks  in  8  chunks per row (row width = cfg_chunks*NTHR); 0 treated as 1.
- cfg_rows  in  YW  rows per frame; 0 treated as 1.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the last pixel is accepted.
- core_rq  out  1  one-cycle request pulse to the core.
- core_cx0  out  32  chunk start x.
- core_cxstep  out  32  per-thread x step (= latched cfg_xstep).
- core_cy  out  32  current row y.
- core_ack  in  1  one-cycle completion pulse from the core.
- core_counters  in  NTHR*CW  thread k (1..11) occupies bits [7k-1:7(k-1)].
- pix_valid  out  1  pixel available.
- pix_ready  in  1  consumer accepts.
- pix_data  out  CW  iteration count.
- pix_x  out  XW  pixel column.
- pix_y  out  YW  pixel row.
- pix_last  out  1  final pixel of the frame.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; both buffer slots empty; configuration latches cleared. Reset mid-frame abandons the frame with no done pulse; the core is reset in parallel on the same reset.
- Configuration latching: on start in IDLE, latch all cfg_* inputs and compute xstep11 = xstep*11 (shift-add, mod 2^32). Set cx = x0, cy = y0, chunk = 0, row = 0. Assert busy from the next cycle.
- FSM states: IDLE, ISSUE, WAIT, ADV, FLUSH.
  - IDLE -> ISSUE on start.
  - ISSUE: if a buffer slot is free, drive core_rq=1 for exactly one cycle with core_cx0/core_cy valid in that cycle, then go to WAIT. Otherwise stay in ISSUE. The free slot checked at issue is reserved for this request.
  - WAIT: on core_ack, write core_counters into the reserved slot in the same cycle, tagged with (chunk, row, last-chunk flag), then go to ADV.
  - ADV (one cycle):
    - Not the last chunk of the row: chunk += 1, cx += xstep11.
    - Last chunk of the row, more rows remain: chunk = 0, cx = x0, row += 1, cy += ystep.
    - Last chunk of the frame: go to FLUSH. Otherwise go to ISSUE.
  - FLUSH: wait until both slots have drained, then pulse done for one cycle, clear busy, return to IDLE.
- Overlap: the next chunk is issued while the previous chunk drains. A 2-slot buffer guarantees a free slot at every ack, so core_counters are never dropped and never sampled after the ack cycle.
- Core input stability: core_cx0, core_cy and core_cxstep are held stable from the issue cycle through ack.
- Serialiser:
  - Drains the oldest full slot, thread 1 first.
  - pix_x = chunk*11 + (k-1); pix_y = row.
  - Advances on pix_valid && pix_ready. Outputs are held while stalled.
  - The slot frees in the cycle its 11th pixel is accepted; that slot may be reserved by ISSUE in the same cycle.
  - pix_last = 1 on pixel k=11 of the final chunk.
  - No bubble between consecutive full slots.
- Ignored inputs: start while busy is ignored; core_ack outside WAIT is ignored.
- Arithmetic: cx and cy wrap modulo 2^32. pix_x wraps at 2^XW; cfg_chunks*11 > 2^XW is unsupported.

Decomposition:
- mand_pkg holds:
  - NTHR, CW, XW, YW constants;
  - the FSM state enum (IDLE, ISSUE, WAIT, ADV, FLUSH);
  - the slot tag struct {chunk, row, last}.
- Sub-module mand_pixbuf: 2-slot ping-pong counter buffer plus 11:1 serialiser, exposing free/reserve/write on the capture side and the pix_* stream on the output side.

Test Plan:
- Single chunk: cfg_chunks=1, cfg_rows=1, x0=0, xstep=4, y0=8; core model acks with counters k -> 7'(k) -> exactly one rq with cx0=0, cxstep=4, cy=8; 11 pixels with data 1..11 and pix_x 0..10; pix_last on the 11th; done one cycle after its acceptance.
- Row and chunk advance: chunks=2, rows=2, xstep=3, ystep=5 -> rq sequence cx0/cy = (x0,y0), (x0+33,y0), (x0,y0+5), (x0+33,y0+5); pix_y switches 0->1 after pixel 21.
- Backpressure: pix_ready held 0 until both slots are full -> third rq withheld; releasing pix_ready yields 22 ordered pixels with no loss, then the third rq issues.
- Ack-cycle capture: core model changes core_counters the cycle after ack -> emitted data equals the ack-cycle values.
- Start while busy is ignored and x0+xstep11 wraps past 2^32 -> cx0 equals the modulo-2^32 sum.
- Reset asserted mid-drain -> next cycle busy=0, pix_valid=0, core_rq=0, no done; a new start runs cleanly.
